// File: rtl/tri_pkg.sv
// Shared constants for the triangle vertex driver: coordinate width, FSM states and
// the fixed vertex table replayed into the rasterizer.
package tri_pkg;

    localparam int CW      = 3;
    localparam int IDX_W   = 4;
    localparam int MAX_TRI = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_V1,
        ST_V2,
        ST_V3,
        ST_WAIT_BUSY,
        ST_COLLECT,
        ST_NEXT,
        ST_DONE
    } state_e;

    // Returns {x, y} of vertex b (0..2) of triangle t; entries past 3 are a filler pattern.
    function automatic logic [2*CW-1:0] vertex_xy(input logic [IDX_W-1:0] t,
                                                  input logic [1:0]       b);
        logic [2*CW-1:0] xy;
        case ({t, b})
            {4'd0, 2'd0}: xy = {3'd1, 3'd2};
            {4'd0, 2'd1}: xy = {3'd6, 3'd2};
            {4'd0, 2'd2}: xy = {3'd3, 3'd6};
            {4'd1, 2'd0}: xy = {3'd0, 3'd0};
            {4'd1, 2'd1}: xy = {3'd7, 3'd0};
            {4'd1, 2'd2}: xy = {3'd0, 3'd7};
            {4'd2, 2'd0}: xy = {3'd2, 3'd5};
            {4'd2, 2'd1}: xy = {3'd5, 3'd5};
            {4'd2, 2'd2}: xy = {3'd4, 3'd1};
            {4'd3, 2'd0}: xy = {3'd7, 3'd7};
            {4'd3, 2'd1}: xy = {3'd0, 3'd4};
            {4'd3, 2'd2}: xy = {3'd4, 3'd0};
            default:      xy = {t[2:0], t[2:0] ^ {1'b0, b}};
        endcase
        return xy;
    endfunction

endpackage

// File: rtl/tri_vertex_rom.sv
// Combinational vertex lookup: (triangle index, beat) -> (x, y). Beat 3 reads as zero.
module tri_vertex_rom
    import tri_pkg::*;
(
    input  logic [IDX_W-1:0] tri_idx_i,
    input  logic [1:0]       beat_i,
    output logic [CW-1:0]    x_o,
    output logic [CW-1:0]    y_o
);

    always_comb begin
        {x_o, y_o} = '0;
        if (beat_i != 2'd3) begin
            {x_o, y_o} = vertex_xy(tri_idx_i, beat_i);
        end
    end

endmodule

// File: rtl/tri_vertex_driver.sv
// Replays the vertex table into the rasterizer (nt + three vertex beats per triangle)
// and counts/latches the returned point stream. All outputs are registered.
module tri_vertex_driver
    import tri_pkg::*;
#(
    parameter int NUM_TRI  = 4,
    parameter int CNT_W    = 8,
    parameter int BUSY_TMO = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             busy_i,
    input  logic             po_i,
    input  logic [CW-1:0]    xi_pt_i,
    input  logic [CW-1:0]    yi_pt_i,
    output logic             nt_o,
    output logic [CW-1:0]    xo_o,
    output logic [CW-1:0]    yo_o,
    output logic [IDX_W-1:0] tri_idx_o,
    output logic [CNT_W-1:0] pt_count_o,
    output logic [CW-1:0]    last_x_o,
    output logic [CW-1:0]    last_y_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int               TMO_W    = $clog2(BUSY_TMO + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRI - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

    state_e             state_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               nt_q;
    logic [CW-1:0]      xo_q;
    logic [CW-1:0]      yo_q;
    logic [IDX_W-1:0]   tri_idx_q;
    logic [CNT_W-1:0]   pt_count_q;
    logic [CNT_W-1:0]   pt_count_d;
    logic [CW-1:0]      last_x_q;
    logic [CW-1:0]      last_y_q;
    logic               done_q;
    logic               err_q;
    logic [1:0]         beat;
    logic [CW-1:0]      rom_x;
    logic [CW-1:0]      rom_y;
    logic               po_ok;

    // The ROM is addressed one beat ahead so each vertex lands in xo/yo as the state enters it.
    always_comb begin
        beat = 2'd0;
        case (state_q)
            ST_V1:   beat = 2'd1;
            ST_V2:   beat = 2'd2;
            default: beat = 2'd0;
        endcase
    end

    tri_vertex_rom u_rom (
        .tri_idx_i (tri_idx_q),
        .beat_i    (beat),
        .x_o       (rom_x),
        .y_o       (rom_y)
    );

    assign po_ok      = (state_q == ST_WAIT_BUSY) || (state_q == ST_COLLECT);
    assign pt_count_d = (&pt_count_q) ? pt_count_q : pt_count_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            nt_q       <= 1'b0;
            xo_q       <= '0;
            yo_q       <= '0;
            tri_idx_q  <= '0;
            pt_count_q <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            nt_q <= 1'b0;
            if (po_i) begin
                if (po_ok) begin
                    pt_count_q <= pt_count_d;
                    last_x_q   <= xi_pt_i;
                    last_y_q   <= yi_pt_i;
                end else begin
                    err_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q   <= ST_WAIT_RDY;
                        tri_idx_q <= '0;
                        done_q    <= 1'b0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (!busy_i) begin
                        state_q    <= ST_V1;
                        nt_q       <= 1'b1;
                        xo_q       <= rom_x;
                        yo_q       <= rom_y;
                        pt_count_q <= '0;
                    end
                end
                ST_V1: begin
                    state_q <= ST_V2;
                    xo_q    <= rom_x;
                    yo_q    <= rom_y;
                end
                ST_V2: begin
                    state_q <= ST_V3;
                    xo_q    <= rom_x;
                    yo_q    <= rom_y;
                end
                ST_V3: begin
                    state_q <= ST_WAIT_BUSY;
                    tmo_q   <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (busy_i) begin
                        state_q <= ST_COLLECT;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_NEXT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (!busy_i) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (tri_idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= ST_WAIT_RDY;
                        tri_idx_q <= tri_idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign nt_o       = nt_q;
    assign xo_o       = xo_q;
    assign yo_o       = yo_q;
    assign tri_idx_o  = tri_idx_q;
    assign pt_count_o = pt_count_q;
    assign last_x_o   = last_x_q;
    assign last_y_o   = last_y_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
